// File: rtl/addsub_display.sv
// ---------------------------------------------------------------------------
// addsub_display
//
// Purpose:
//   Takes the signed result of an 8-bit adder-subtractor and shows it on a
//   four-digit, multiplexed, common-anode 7-segment display. A load request
//   captures the result. The magnitude is converted to BCD by a sequential
//   double-dabble engine, one bit per clock. The finished digits are then
//   copied into display registers in a single step. The scanner only reads
//   those registers, so a half-converted value never reaches the segments.
//
// Parameters:
//   REFRESH_CYCLES - clock cycles each digit stays lit (2 or more)
//
// Ports:
//   clk      in   1  single clock, rising edge
//   rst_n    in   1  synchronous active-low reset
//   S        in   8  adder-subtractor result
//   overflow in   1  adder-subtractor overflow flag
//   neg      in   1  adder-subtractor negative flag
//   load     in   1  capture request, sampled every cycle while idle
//   busy     out  1  high while a conversion is in progress (registered)
//   seg      out  7  active-low segments, seg[0]=a .. seg[6]=g
//   dp       out  1  active-low decimal point, lit as the overflow marker
//   an       out  4  active-low digit enables: ones, tens, hundreds, sign
// ---------------------------------------------------------------------------
module addsub_display #(
   parameter int REFRESH_CYCLES = 100000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] S,
   input  logic       overflow,
   input  logic       neg,
   input  logic       load,
   output logic       busy,
   output logic [6:0] seg,
   output logic       dp,
   output logic [3:0] an
);

   localparam int CNT_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
   localparam logic [CNT_W-1:0] REFRESH_LAST = CNT_W'(REFRESH_CYCLES - 1);
   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_MINUS = 7'b0111111;

   typedef enum logic [1:0] {
      IDLE,
      CONV,
      DONE
   } state_t;

   state_t      state;
   logic [2:0]  bit_cnt;
   logic [19:0] dd_reg;
   logic [19:0] dd_next;
   logic [7:0]  magnitude;
   logic        cap_neg;
   logic        cap_ovf;

   logic [3:0]  disp_hund;
   logic [3:0]  disp_tens;
   logic [3:0]  disp_ones;
   logic        disp_sign;
   logic        disp_ovf;

   logic [CNT_W-1:0] refresh_cnt;
   logic [1:0]       digit_idx;

   // Map one BCD digit to its active-low segment pattern (a..g = bit 0..6).
   // Codes above 9 never occur, but they fall back to a blank digit.
   function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
      logic [6:0] p;
      case (d)
         4'd0:    p = 7'b1000000;
         4'd1:    p = 7'b1111001;
         4'd2:    p = 7'b0100100;
         4'd3:    p = 7'b0110000;
         4'd4:    p = 7'b0011001;
         4'd5:    p = 7'b0010010;
         4'd6:    p = 7'b0000010;
         4'd7:    p = 7'b1111000;
         4'd8:    p = 7'b0000000;
         4'd9:    p = 7'b0010000;
         default: p = SEG_BLANK;
      endcase
      return p;
   endfunction

   // Unsigned magnitude of the incoming result. A negative result arrives in
   // two's complement, so it is negated modulo 256. 8'h80 therefore becomes
   // 128, which still fits in the 8-bit shift register.
   always_comb begin
      magnitude = neg ? (~S + 8'd1) : S;
   end

   // One double-dabble step on the combined {hundreds, tens, ones, binary}
   // word. Any BCD nibble of 5 or more gets 3 added before the shift. That
   // way the left shift carries correctly into the next decimal digit.
   always_comb begin
      dd_next = dd_reg;
      for (int i = 0; i < 3; i++) begin
         if (dd_next[8 + 4*i +: 4] >= 4'd5) begin
            dd_next[8 + 4*i +: 4] = dd_next[8 + 4*i +: 4] + 4'd3;
         end
      end
      dd_next = dd_next << 1;
   end

   // Conversion controller. IDLE waits for load and captures the operands.
   // CONV performs exactly eight dabble steps, counted by bit_cnt. DONE
   // copies the finished BCD together with the captured sign and overflow
   // into the display registers in one edge. busy rises on the capture edge
   // and falls on the DONE edge. A load seen outside IDLE is dropped. Reset
   // also clears the display, so an aborted conversion leaves it at 0.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         busy      <= 1'b0;
         bit_cnt   <= 3'd0;
         dd_reg    <= 20'd0;
         cap_neg   <= 1'b0;
         cap_ovf   <= 1'b0;
         disp_hund <= 4'd0;
         disp_tens <= 4'd0;
         disp_ones <= 4'd0;
         disp_sign <= 1'b0;
         disp_ovf  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (load) begin
                  dd_reg  <= {12'd0, magnitude};
                  cap_neg <= neg;
                  cap_ovf <= overflow;
                  bit_cnt <= 3'd0;
                  busy    <= 1'b1;
                  state   <= CONV;
               end
            end
            CONV: begin
               dd_reg  <= dd_next;
               bit_cnt <= bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) begin
                  state <= DONE;
               end
            end
            DONE: begin
               disp_hund <= dd_reg[19:16];
               disp_tens <= dd_reg[15:12];
               disp_ones <= dd_reg[11:8];
               disp_sign <= cap_neg;
               disp_ovf  <= cap_ovf;
               busy      <= 1'b0;
               state     <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

   // Display scan timer. Each digit stays lit for REFRESH_CYCLES clocks.
   // When the counter wraps, the active digit steps ones -> tens ->
   // hundreds -> sign and then back to ones.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         refresh_cnt <= '0;
         digit_idx   <= 2'd0;
      end else if (refresh_cnt == REFRESH_LAST) begin
         refresh_cnt <= '0;
         digit_idx   <= digit_idx + 2'd1;
      end else begin
         refresh_cnt <= refresh_cnt + CNT_W'(1);
      end
   end

   // Output decode. It reads only the display registers and the scan index,
   // so the inputs have no path to the pins. Leading zeros are blanked: a
   // zero hundreds digit is dark, and a zero tens digit is dark only when
   // hundreds is also zero. The ones digit is always shown. The sign digit
   // shows a minus for a negative result. Its decimal point is the overflow
   // marker.
   always_comb begin
      an  = ~(4'b0001 << digit_idx);
      seg = SEG_BLANK;
      dp  = 1'b1;
      case (digit_idx)
         2'd0: seg = bcd_to_seg(disp_ones);
         2'd1: begin
            if ((disp_hund != 4'd0) || (disp_tens != 4'd0)) begin
               seg = bcd_to_seg(disp_tens);
            end
         end
         2'd2: begin
            if (disp_hund != 4'd0) begin
               seg = bcd_to_seg(disp_hund);
            end
         end
         default: begin
            if (disp_sign) begin
               seg = SEG_MINUS;
            end
            dp = ~disp_ovf;
         end
      endcase
   end

endmodule
